irda_mir_rx_ctrl: RTL

IRDA_MIR_RX_CTRL -- requirements
Module: irda_mir_rx_ctrl

---
 rtl/irda_mir_pkg.sv | 30 +++
 rtl/irda_mir_crc16.sv | 35 +++
 rtl/irda_mir_rx_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/irda_mir_pkg.sv
// irda_mir_pkg -- shared definitions for the IrDA MIR receive path.
//   state_t      : receive controller states (IDLE, HUNT, FLAG, DATA)
//   MIR_FLAG     : STA/STO flag pattern 01111110
//   CRC_POLY     : CRC-16-CCITT polynomial 0x1021, bit-reversed for LSB-first use
//   CRC_INIT     : CRC register preset
//   CRC_RESIDUE  : register value after a frame plus a correct FCS
//   crc16_step   : one bit-serial CRC update
package irda_mir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_FLAG = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [7:0]  MIR_FLAG    = 8'b0111_1110;
  localparam logic [15:0] CRC_POLY    = 16'h8408;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'hF0B8;

  // Bits arrive LSB first, so the register shifts right and the reflected
  // polynomial is folded in when the outgoing bit differs from the input.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return (crc >> 1) ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/irda_mir_crc16.sv
// irda_mir_crc16 -- bit-serial CRC-16-CCITT (reflected) accumulator.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset (register -> preset)
//   i_clr   : reload the preset; when i_en is also high the bit is folded
//             into a freshly preset register so the first bit is not lost
//   i_en    : fold i_bit into the register
//   i_bit   : serial data bit, LSB of each byte first
//   o_crc   : current register contents
module irda_mir_crc16
  import irda_mir_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc16_step(i_clr ? CRC_INIT : r_crc, i_bit);
    end else if (i_clr) begin
      r_crc <= CRC_INIT;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/irda_mir_rx_ctrl.sv
// irda_mir_rx_ctrl -- IrDA MIR receive framing controller.
// Takes the bit stream from the start/stop detector, tracks STA/STO flags,
// removes stuffed zeros, assembles bytes (LSB first) and reports frame
// boundaries and errors.
// Optional feature: define IRDA_MIR_CRC_EN to check the frame FCS
// (CRC-16-CCITT); without it crc_err is tied low and no CRC logic exists.
// Parameter:
//   MAX_LEN          : max destuffed bytes per frame, FCS included
// Ports:
//   clk              : clock, rising edge
//   wb_rst_i         : synchronous active-low reset
//   rx_en            : MIR receive enable
//   mir_rxbit_enable : one-clock strobe per received MIR bit
//   std_o            : detector bit output
//   std_is_good_bit  : std_o is a valid stream bit
//   std_st_detected  : detector saw a flag
//   std_restart      : restart pulse to the detector
//   rx_data          : destuffed byte
//   rx_data_valid    : strobe qualifying rx_data
//   frame_start      : strobe on the first data bit of a frame
//   frame_end        : strobe on the STO flag of a good frame
//   frame_err        : strobe on abort, overlength or residual bits
//   crc_err          : FCS check result, valid with frame_end
module irda_mir_rx_ctrl
  import irda_mir_pkg::*;
#(
  parameter int MAX_LEN = 2051
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       rx_en,
  input  logic       mir_rxbit_enable,
  input  logic       std_o,
  input  logic       std_is_good_bit,
  input  logic       std_st_detected,
  output logic       std_restart,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err,
  output logic       crc_err
);

  localparam logic [11:0] LP_MAX = 12'(MAX_LEN);
  localparam logic [11:0] LP_SAT = 12'(MAX_LEN + 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_ones;
  logic [2:0]  r_bitcnt;
  logic [11:0] r_bytecnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_restart, r_valid, r_fstart, r_fend, r_ferr, r_crc_err;

  logic        w_restart_nxt, w_valid_nxt, w_fstart_nxt, w_fend_nxt, w_ferr_nxt;
  logic        w_take;
  logic        w_flag, w_bit_ok;
  logic [2:0]  w_ones_inc;
  logic        w_abort, w_keep_bit, w_byte_done, w_overlen;
  logic        w_crc_bad;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v >= LP_SAT) ? LP_SAT : v + 12'd1;
  endfunction

  assign w_flag   = mir_rxbit_enable & std_st_detected;
  assign w_bit_ok = mir_rxbit_enable & std_is_good_bit & ~std_st_detected;

  // Classification of the current bit against the run of ones so far.
  // A seventh 1 is an abort; a 0 after exactly five 1s is a stuffed zero.
  assign w_ones_inc  = r_ones + 3'd1;
  assign w_abort     = std_o & (r_ones == 3'd6);
  assign w_keep_bit  = std_o | (r_ones != 3'd5);
  assign w_byte_done = w_keep_bit & (r_bitcnt == 3'd7);
  assign w_overlen   = w_byte_done & (r_bytecnt >= LP_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_restart_nxt = 1'b0;
    w_valid_nxt   = 1'b0;
    w_fstart_nxt  = 1'b0;
    w_fend_nxt    = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_take        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_en) begin
          w_state_nxt   = ST_HUNT;
          w_restart_nxt = 1'b1;
        end
      end
      ST_HUNT: begin
        if (w_flag) w_state_nxt = ST_FLAG;
      end
      ST_FLAG: begin
        // Repeated flags keep us here; the first non-flag bit is data.
        if (w_bit_ok) begin
          w_state_nxt  = ST_DATA;
          w_fstart_nxt = 1'b1;
          w_take       = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_flag) begin
          // The closing flag doubles as the opening flag of the next frame.
          w_state_nxt = ST_FLAG;
          if (r_bitcnt == 3'd0 && r_bytecnt != 12'd0) w_fend_nxt = 1'b1;
          else                                        w_ferr_nxt = 1'b1;
        end else if (w_bit_ok) begin
          if (w_abort || w_overlen) begin
            w_state_nxt   = ST_HUNT;
            w_ferr_nxt    = 1'b1;
            w_restart_nxt = 1'b1;
          end else begin
            w_take      = 1'b1;
            w_valid_nxt = w_byte_done;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Disabling the receiver overrides everything and silently drops the frame.
    if (!rx_en && r_state != ST_IDLE) begin
      w_state_nxt   = ST_IDLE;
      w_restart_nxt = 1'b1;
      w_valid_nxt   = 1'b0;
      w_fstart_nxt  = 1'b0;
      w_fend_nxt    = 1'b0;
      w_ferr_nxt    = 1'b0;
      w_take        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_restart <= 1'b0;
      r_valid   <= 1'b0;
      r_fstart  <= 1'b0;
      r_fend    <= 1'b0;
      r_ferr    <= 1'b0;
      r_crc_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_restart <= w_restart_nxt;
      r_valid   <= w_valid_nxt;
      r_fstart  <= w_fstart_nxt;
      r_fend    <= w_fend_nxt;
      r_ferr    <= w_ferr_nxt;
      r_crc_err <= w_fend_nxt & w_crc_bad;
    end
  end

  // Frame counters restart whenever the controller is not (or no longer) in DATA.
  always_ff @(posedge clk) begin
    if (!wb_rst_i) begin
      r_ones    <= 3'd0;
      r_bitcnt  <= 3'd0;
      r_bytecnt <= 12'd0;
      r_rx_data <= 8'h00;
    end else begin
      if (w_valid_nxt) r_rx_data <= {std_o, r_shift[7:1]};
      if (w_state_nxt != ST_DATA) begin
        r_ones    <= 3'd0;
        r_bitcnt  <= 3'd0;
        r_bytecnt <= 12'd0;
      end else if (w_take) begin
        r_ones <= std_o ? w_ones_inc : 3'd0;
        if (w_keep_bit) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          if (w_byte_done) r_bytecnt <= sat_inc(r_bytecnt);
        end
      end
    end
  end

  // Byte assembler: LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (w_take && w_keep_bit) r_shift <= {std_o, r_shift[7:1]};
  end

`ifdef IRDA_MIR_CRC_EN
  logic [15:0] w_crc;

  irda_mir_crc16 u_crc16 (
    .clk   (clk),
    .rst_n (wb_rst_i),
    .i_clr (r_state != ST_DATA),
    .i_en  (w_take & w_keep_bit),
    .i_bit (std_o),
    .o_crc (w_crc)
  );

  assign w_crc_bad = (w_crc != CRC_RESIDUE);
`else
  assign w_crc_bad = 1'b0;
`endif

  assign std_restart   = r_restart;
  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_valid;
  assign frame_start   = r_fstart;
  assign frame_end     = r_fend;
  assign frame_err     = r_ferr;
  assign crc_err       = r_crc_err;

endmodule
